opsel_mux_pipe: RTL and testbench

- Parametrised successor of the ALU operand-select mux.
- Selects one of NUM_IN operand sources (register file, immediate, forwarded results, constants) and drives the ALU operand through a one-stage registered pipeline with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under back-pressure.
- Out-of-range selects drive DEFAULT_VAL and are flagged.

---
 rtl/opsel_mux_pipe.sv | 97 +++++++++
 tb/tb_opsel_mux_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/opsel_mux_pipe.sv
// opsel_mux_pipe: operand-select mux with a registered valid/ready stage and 2-entry skid buffer.
// Define OPSEL_STALL_CNT_EN to build the saturating back-pressure counter on stall_cnt.
module opsel_mux_pipe #(
    parameter int WIDTH = 8,
    parameter int NUM_IN = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b1}},
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             stall_cnt
);
    logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, item_data;
    logic             main_err_q, main_err_d, skid_err_q, skid_err_d, item_err;
    logic             out_valid_q, out_valid_d, skid_full_q, skid_full_d;
    logic             accept, pop, legal;
    logic [SEL_W:0]   sel_ext;

    // Widened compare keeps the legality test meaningful when NUM_IN fills the select range.
    assign sel_ext   = {1'b0, sel};
    assign legal     = sel_ext < (SEL_W+1)'(NUM_IN);
    assign item_data = legal ? in_data[sel*WIDTH +: WIDTH] : DEFAULT_VAL;
    assign item_err  = ~legal;

    assign in_ready  = ~skid_full_q & ~rst;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid_q & out_ready;
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;
    assign out_valid = out_valid_q;

    always_comb begin
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        out_valid_d = out_valid_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        skid_full_d = skid_full_q;
        if (~out_valid_q | pop) begin
            if (skid_full_q) begin
                main_data_d = skid_data_q;
                main_err_d  = skid_err_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                main_data_d = item_data;
                main_err_d  = item_err;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d = item_data;
            skid_err_d  = item_err;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            out_valid_q <= out_valid_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            skid_full_q <= skid_full_d;
        end
    end

`ifdef OPSEL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    assign stall_d   = (out_valid_q & ~out_ready & ~&stall_q) ? stall_q + 16'd1 : stall_q;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_opsel_mux_pipe.sv
// tb_opsel_mux_pipe: directed checks of opsel_mux_pipe with NUM_IN=4 and NUM_IN=3 instances.
module tb_opsel_mux_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data_a;
    logic [1:0]  sel_a;
    logic        in_valid_a, in_ready_a, out_err_a, out_valid_a, out_ready_a;
    logic [7:0]  out_data_a;
    logic [15:0] stall_cnt_a;
    logic [23:0] in_data_b;
    logic [1:0]  sel_b;
    logic        in_valid_b, in_ready_b, out_err_b, out_valid_b, out_ready_b;
    logic [7:0]  out_data_b;
    logic [15:0] stall_cnt_b;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] stall_exp;

    always #5 clk = ~clk;

    opsel_mux_pipe #(.WIDTH(8), .NUM_IN(4)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .sel(sel_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .out_data(out_data_a), .out_err(out_err_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .stall_cnt(stall_cnt_a)
    );

    opsel_mux_pipe #(.WIDTH(8), .NUM_IN(3)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .sel(sel_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_err(out_err_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .stall_cnt(stall_cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] stream [4];
        stream = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef OPSEL_STALL_CNT_EN
        stall_exp = 16'd5;
`else
        stall_exp = 16'd0;
`endif
        rst = 1'b1;
        in_data_a = 32'h0;
        sel_a = 2'd0;
        in_valid_a = 1'b1;
        out_ready_a = 1'b1;
        in_data_b = 24'h03_5A_01;
        sel_b = 2'd0;
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_data", out_data_a, 8'h00);
        chk("rst_out_err", out_err_a, 0);
        chk("rst_stall_cnt", stall_cnt_a, 0);
        rst = 1'b0;
        in_valid_a = 1'b0;
        tick();
        chk("idle_in_ready", in_ready_a, 1);
        chk("idle_out_valid", out_valid_a, 0);

        in_data_a = 32'h44_33_22_11;
        in_valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel_a = 2'(i);
            tick();
            chk("stream_valid", out_valid_a, 1);
            chk("stream_data", out_data_a, stream[i]);
            chk("stream_err", out_err_a, 0);
            chk("stream_in_ready", in_ready_a, 1);
        end
        in_valid_a = 1'b0;
        in_data_a = 32'hDE_AD_BE_EF;
        tick();
        chk("drain_valid", out_valid_a, 0);
        chk("drain_hold_data", out_data_a, 8'h44);

        out_ready_a = 1'b0;
        in_valid_a = 1'b1;
        sel_a = 2'd0;
        in_data_a = 32'h00_00_00_A1;
        tick();
        chk("bp_a_main", out_data_a, 8'hA1);
        chk("bp_a_ready", in_ready_a, 1);
        in_data_a = 32'h00_00_00_B2;
        tick();
        chk("bp_skid_ready", in_ready_a, 0);
        chk("bp_hold_a", out_data_a, 8'hA1);
        in_data_a = 32'h00_00_00_C3;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_hold_a_long", out_data_a, 8'hA1);
        chk("bp_ready_low", in_ready_a, 0);
        chk("stall_cnt", stall_cnt_a, stall_exp);
        out_ready_a = 1'b1;
        tick();
        chk("bp_b_out", out_data_a, 8'hB2);
        chk("bp_b_valid", out_valid_a, 1);
        chk("bp_ready_back", in_ready_a, 1);
        chk("stall_cnt_hold", stall_cnt_a, stall_exp);
        tick();
        chk("bp_c_out", out_data_a, 8'hC3);
        chk("bp_c_valid", out_valid_a, 1);
        in_valid_a = 1'b0;
        tick();
        chk("bp_empty", out_valid_a, 0);

        out_ready_a = 1'b0;
        in_valid_a = 1'b1;
        in_data_a = 32'h00_00_00_D4;
        tick();
        in_data_a = 32'h00_00_00_E5;
        tick();
        chk("mid_skid_full", in_ready_a, 0);
        rst = 1'b1;
        in_valid_a = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid_a, 0);
        chk("mid_rst_ready", in_ready_a, 0);
        chk("mid_rst_data", out_data_a, 8'h00);
        chk("mid_rst_stall", stall_cnt_a, 0);
        rst = 1'b0;
        out_ready_a = 1'b1;
        tick();
        chk("post_rst_valid", out_valid_a, 0);
        chk("post_rst_ready", in_ready_a, 1);
        tick();
        chk("post_rst_no_stale", out_valid_a, 0);

        in_valid_b = 1'b1;
        sel_b = 2'd3;
        tick();
        chk("illegal_data", out_data_b, 8'hFF);
        chk("illegal_err", out_err_b, 1);
        chk("illegal_valid", out_valid_b, 1);
        sel_b = 2'd1;
        tick();
        chk("legal1_data", out_data_b, 8'h5A);
        chk("legal1_err", out_err_b, 0);
        sel_b = 2'd2;
        tick();
        chk("legal2_data", out_data_b, 8'h03);
        chk("legal2_err", out_err_b, 0);
        in_valid_b = 1'b0;
        tick();
        chk("b_drain", out_valid_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
